// File: rtl/axi_pkg.sv
// Shared AXI read-side types for the MM2S stub memory.
//  axi_burst_e : AR burst encodings
//  axi_resp_e  : R response encodings
//  rd_state_e  : read responder FSM states
//  beat_bytes  : bytes carried by one data-bus beat
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCEPT = 2'b01,
    BURST  = 2'b10
  } rd_state_e;

  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Beat address generator for the read responder.
//  Latches the AR fields on load and tracks the beat counter. Outputs describe
//  the beat being fetched this cycle: beat 0 from the live AR inputs on load,
//  otherwise beat (count+1) from the latched fields on advance.
// Ports:
//  clk, rst_n         clock, async active-low reset
//  load               AR handshake this cycle
//  advance            R handshake on a non-final beat this cycle
//  ar_addr/len/size/burst  AR channel fields
//  word_idx           memory word index of the fetched beat
//  err                fetched beat must return SLVERR
//  last               fetched beat is the final one of the burst
module axi_rd_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  err,
  output logic                  last
);

  localparam int unsigned           SIZE_LOG2 = $clog2(beat_bytes(DATA_WIDTH));
  localparam logic [2:0]            SIZE_OK   = SIZE_LOG2[2:0];
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WORDS     = ADDR_WIDTH'(MEM_WORDS);

  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;

  logic [ADDR_WIDTH-1:0] cur_start;
  logic [7:0]            cur_len;
  logic [2:0]            cur_size;
  logic [1:0]            cur_burst;
  logic [7:0]            cur_n;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH:0]   rel_addr;
  logic [ADDR_WIDTH-1:0] word_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      start_q <= start_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    start_d = start_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    if (load) begin
      start_d = ar_addr;
      len_d   = ar_len;
      size_d  = ar_size;
      burst_d = ar_burst;
      beat_d  = '0;
    end else if (advance) begin
      beat_d = beat_q + 8'd1;
    end
  end

  // Beat 0 is fetched on the AR handshake edge, before the fields are latched,
  // so the live AR inputs are used for it.
  always_comb begin
    cur_start = load ? ar_addr  : start_q;
    cur_len   = load ? ar_len   : len_q;
    cur_size  = load ? ar_size  : size_q;
    cur_burst = load ? ar_burst : burst_q;
    cur_n     = load ? 8'd0     : beat_q + 8'd1;
    beat_addr = (cur_burst == FIXED) ? cur_start
                                     : cur_start + (ADDR_WIDTH'(cur_n) << cur_size);
    // Extra MSB is the borrow: set when the beat address lies below BASE.
    rel_addr  = {1'b0, beat_addr} - {1'b0, BASE};
    word_off  = rel_addr[ADDR_WIDTH-1:0] >> SIZE_LOG2;
    word_idx  = word_off[IDX_W-1:0];
    err       = ((cur_burst != FIXED) && (cur_burst != INCR)) ||
                (cur_size != SIZE_OK) ||
                rel_addr[ADDR_WIDTH] ||
                (word_off >= WORDS);
    last      = (cur_n == cur_len);
  end

endmodule

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-only memory responder used as the stub system memory behind the
// DMA MM2S read port. Accepts one AR burst at a time, returns beats from an
// internal word array with a one-cycle registered read, and answers illegal
// or out-of-range beats with SLVERR and zero data. A backdoor port preloads
// and inspects the array.
// Ports:
//  axi_aclk, axi_resetn         clock, async active-low reset
//  araddr/arlen/arsize/arburst  AR burst description
//  arprot, arcache              accepted and ignored
//  arvalid, arready             AR handshake
//  rdata, rresp, rlast          R beat payload
//  rvalid, rready               R handshake
//  bd_we, bd_addr, bd_wdata     backdoor word write
//  bd_rdata                     backdoor word read, combinational from bd_addr
module axi_rd_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned AR_DELAY   = 0
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic [2:0]                   arprot,
  input  logic [3:0]                   arcache,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]        bd_wdata,
  output logic [DATA_WIDTH-1:0]        bd_rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  rd_state_e             state_q, state_d;
  logic [3:0]            dly_q, dly_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  load;
  logic                  advance;
  logic [IDX_W-1:0]      word_idx;
  logic                  beat_err;
  logic                  beat_last;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_ar;
  assign unused_ar = ^{arprot, arcache};

  axi_rd_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_addr_gen (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .load     (load),
    .advance  (advance),
    .ar_addr  (araddr),
    .ar_len   (arlen),
    .ar_size  (arsize),
    .ar_burst (arburst),
    .word_idx (word_idx),
    .err      (beat_err),
    .last     (beat_last)
  );

  // State register
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    unique case (state_q)
      IDLE: begin
        if (arvalid) begin
          state_d = ACCEPT;
          dly_d   = 4'(AR_DELAY);
        end
      end
      ACCEPT: begin
        if (dly_q != '0) begin
          dly_d = dly_q - 4'd1;
        end else if (arvalid) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (rvalid_q && rready && rlast_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    arready = (state_q == ACCEPT) && (dly_q == '0);
    load    = arready && arvalid;
    advance = (state_q == BURST) && rvalid_q && rready && !rlast_q;
  end

  // R channel: a new beat is fetched on the AR handshake or on the handshake
  // of a non-final beat; otherwise the current beat is held until taken.
  always_comb begin
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (load || advance) begin
      rvalid_d = 1'b1;
      rlast_d  = beat_last;
      rresp_d  = beat_err ? SLVERR : OKAY;
      rdata_d  = beat_err ? '0 : mem[word_idx];
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Array has no reset. A read fetched in the same cycle as a backdoor write
  // to the same word samples the old contents.
  always_ff @(posedge axi_aclk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
  end

  assign bd_rdata = mem[bd_addr];

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;

endmodule
